address_register_file_param: RTL and testbench

//   Parametrised successor of the 3-register address register file (PC/SP/AR).

---
 rtl/arf_pkg.sv | 24 ++
 rtl/addr_reg_cell.sv | 32 +++
 rtl/address_register_file_param.sv | 95 +++++++++
 tb/tb_address_register_file_param.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/arf_pkg.sv
// Shared encodings for the address register file: operation codes and step sizes.
package arf_pkg;

  typedef enum logic [1:0] {
    FS_DEC  = 2'b00,
    FS_INC  = 2'b01,
    FS_LOAD = 2'b10,
    FS_CLR  = 2'b11
  } fun_sel_e;

  typedef enum logic [1:0] {
    STEP_1 = 2'b00,
    STEP_2 = 2'b01,
    STEP_4 = 2'b10,
    STEP_8 = 2'b11
  } step_e;

  localparam int unsigned AMOUNT_W = 4;

  function automatic logic [AMOUNT_W-1:0] step_to_amount(input logic [1:0] step);
    return AMOUNT_W'(1) << step;
  endfunction

endpackage

// File: rtl/addr_reg_cell.sv
// One address register: clear, load, increment/decrement by a given amount.
module addr_reg_cell
  import arf_pkg::*;
#(
  parameter int unsigned          WIDTH     = 16,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    hold,
  input  fun_sel_e                fun_sel,
  input  logic [AMOUNT_W-1:0]     amount,
  input  logic [WIDTH-1:0]        d,
  output logic [WIDTH-1:0]        q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en && !hold) begin
      case (fun_sel)
        FS_DEC:  q <= q - WIDTH'(amount);
        FS_INC:  q <= q + WIDTH'(amount);
        FS_LOAD: q <= d;
        FS_CLR:  q <= '0;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/address_register_file_param.sv
// Parametrised address register file with a guarded, downward-growing stack pointer
// and two combinational read ports.
module address_register_file_param
  import arf_pkg::*;
#(
  parameter int unsigned      WIDTH    = 16,
  parameter int unsigned      NUM_REGS = 4,
  parameter int unsigned      PC_IDX   = 0,
  parameter int unsigned      SP_IDX   = 1,
  parameter logic [WIDTH-1:0] PC_RESET = 16'h0000,
  parameter logic [WIDTH-1:0] SP_BASE  = 16'h07FF,
  parameter logic [WIDTH-1:0] SP_LIMIT = 16'h0400,
  localparam int unsigned     SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [WIDTH-1:0]    I,
  input  logic [1:0]          FunSel,
  input  logic [1:0]          Step,
  input  logic [NUM_REGS-1:0] RegSel,
  input  logic [SEL_W-1:0]    OutCSel,
  input  logic [SEL_W-1:0]    OutDSel,
  output logic [WIDTH-1:0]    OutC,
  output logic [WIDTH-1:0]    OutD,
  output logic                SpOverflow,
  output logic                SpUnderflow
);

  logic [NUM_REGS-1:0][WIDTH-1:0] regs;
  fun_sel_e                       fs;
  logic [AMOUNT_W-1:0]            amount;
  logic [WIDTH:0]                 sp_ext;
  logic [WIDTH:0]                 amount_ext;
  logic                           sp_en;
  logic                           dec_viol;
  logic                           inc_viol;
  logic                           sp_hold;

  assign fs         = fun_sel_e'(FunSel);
  assign amount     = step_to_amount(Step);
  assign sp_en      = RegSel[SP_IDX];
  assign sp_ext     = {1'b0, regs[SP_IDX]};
  assign amount_ext = (WIDTH + 1)'(amount);

  // Compare with one extra bit so the bound check never sees a wrapped result.
  assign dec_viol = sp_ext < ({1'b0, SP_LIMIT} + amount_ext);
  assign inc_viol = (sp_ext + amount_ext) > {1'b0, SP_BASE};
  assign sp_hold  = sp_en && (((fs == FS_DEC) && dec_viol) || ((fs == FS_INC) && inc_viol));

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_cell
    localparam logic [WIDTH-1:0] RV = (k == SP_IDX) ? SP_BASE :
                                      (k == PC_IDX) ? PC_RESET : '0;
    addr_reg_cell #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RV)
    ) u_cell (
      .clk     (Clock),
      .rst     (Reset),
      .en      (RegSel[k]),
      .hold    ((k == SP_IDX) ? sp_hold : 1'b0),
      .fun_sel (fs),
      .amount  (amount),
      .d       (I),
      .q       (regs[k])
    );
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      SpOverflow  <= 1'b0;
      SpUnderflow <= 1'b0;
    end else if (sp_en) begin
      case (fs)
        FS_LOAD: begin
          SpOverflow  <= 1'b0;
          SpUnderflow <= 1'b0;
        end
        FS_DEC: if (dec_viol) SpOverflow <= 1'b1;
        FS_INC: if (inc_viol) SpUnderflow <= 1'b1;
        default: ;
      endcase
    end
  end

  // Selects beyond NUM_REGS match no entry and read as zero.
  always_comb begin
    OutC = '0;
    OutD = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (OutCSel == SEL_W'(k)) OutC = regs[k];
      if (OutDSel == SEL_W'(k)) OutD = regs[k];
    end
  end

endmodule

// File: tb/tb_address_register_file_param.sv
// Directed bench for address_register_file_param with default parameters.
module tb_address_register_file_param;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] I;
  logic [1:0]  FunSel;
  logic [1:0]  Step;
  logic [3:0]  RegSel;
  logic [1:0]  OutCSel;
  logic [1:0]  OutDSel;
  logic [15:0] OutC;
  logic [15:0] OutD;
  logic        SpOverflow;
  logic        SpUnderflow;

  int errors = 0;
  int checks = 0;

  address_register_file_param #(
    .WIDTH    (16),
    .NUM_REGS (4),
    .PC_IDX   (0),
    .SP_IDX   (1),
    .PC_RESET (16'h0000),
    .SP_BASE  (16'h07FF),
    .SP_LIMIT (16'h0400)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .I           (I),
    .FunSel      (FunSel),
    .Step        (Step),
    .RegSel      (RegSel),
    .OutCSel     (OutCSel),
    .OutDSel     (OutDSel),
    .OutC        (OutC),
    .OutD        (OutD),
    .SpOverflow  (SpOverflow),
    .SpUnderflow (SpUnderflow)
  );

  always #5 Clock = ~Clock;

  // Apply one operation for one clock edge, then idle the write enables.
  task automatic op(input logic [3:0] sel, input logic [1:0] fs, input logic [1:0] st,
                    input logic [15:0] data);
    RegSel = sel; FunSel = fs; Step = st; I = data;
    @(posedge Clock); #1;
    RegSel = 4'b0000;
  endtask

  task automatic rd(input logic [1:0] idx, output logic [15:0] v);
    OutCSel = idx; #1; v = OutC;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    Reset = 1'b1; RegSel = 4'b1111; FunSel = 2'b01; Step = 2'b11; I = 16'hAAAA;
    @(posedge Clock); #1;
    Reset = 1'b0; RegSel = 4'b0000;
    OutCSel = 2'd0; OutDSel = 2'd1; #1;
    checks++; if (OutC !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want %h", OutC, 16'h0000); end
    checks++; if (OutD !== 16'h07FF) begin errors++; $display("FAIL reset_sp: got %h want %h", OutD, 16'h07FF); end
    checks++; if ({SpOverflow, SpUnderflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {SpOverflow, SpUnderflow}); end
    rd(2'd3, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_r3: got %h want %h", v, 16'h0000); end
  endtask

  task automatic test_pc_inc();
    logic [15:0] v;
    for (int n = 1; n <= 3; n++) begin
      op(4'b0001, 2'b01, 2'b01, 16'h0000);
      rd(2'd0, v);
      checks++; if (v !== 16'(2 * n)) begin errors++; $display("FAIL pc_inc%0d: got %h want %h", n, v, 16'(2 * n)); end
    end
    rd(2'd1, v);
    checks++; if (v !== 16'h07FF) begin errors++; $display("FAIL pc_inc_sp_hold: got %h want %h", v, 16'h07FF); end
    Reset = 1'b1;
    op(4'b0001, 2'b01, 2'b01, 16'h0000);
    Reset = 1'b0;
    rd(2'd0, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL pc_reset_wins: got %h want %h", v, 16'h0000); end
  endtask

  task automatic test_wrap();
    logic [15:0] v;
    op(4'b0100, 2'b10, 2'b00, 16'h0000);
    op(4'b0100, 2'b00, 2'b00, 16'h0000);
    rd(2'd2, v);
    checks++; if (v !== 16'hFFFF) begin errors++; $display("FAIL wrap_dec: got %h want %h", v, 16'hFFFF); end
    op(4'b0100, 2'b01, 2'b11, 16'h0000);
    rd(2'd2, v);
    checks++; if (v !== 16'h0007) begin errors++; $display("FAIL wrap_inc: got %h want %h", v, 16'h0007); end
  endtask

  task automatic test_sp_overflow();
    logic [15:0] v;
    op(4'b0010, 2'b10, 2'b00, 16'h0402);
    op(4'b0010, 2'b00, 2'b01, 16'h0000);
    rd(2'd1, v);
    checks++; if (v !== 16'h0400) begin errors++; $display("FAIL sp_dec_limit: got %h want %h", v, 16'h0400); end
    checks++; if (SpOverflow !== 1'b0) begin errors++; $display("FAIL sp_limit_noflag: got %b want 0", SpOverflow); end
    op(4'b0010, 2'b00, 2'b00, 16'h0000);
    rd(2'd1, v);
    checks++; if (v !== 16'h0400) begin errors++; $display("FAIL sp_ovf_hold: got %h want %h", v, 16'h0400); end
    checks++; if (SpOverflow !== 1'b1) begin errors++; $display("FAIL sp_ovf_set: got %b want 1", SpOverflow); end
    op(4'b0010, 2'b01, 2'b00, 16'h0000);
    rd(2'd1, v);
    checks++; if (v !== 16'h0401) begin errors++; $display("FAIL sp_inc_after_ovf: got %h want %h", v, 16'h0401); end
    checks++; if (SpOverflow !== 1'b1) begin errors++; $display("FAIL sp_ovf_sticky: got %b want 1", SpOverflow); end
    op(4'b0010, 2'b10, 2'b00, 16'h0500);
    checks++; if (SpOverflow !== 1'b0) begin errors++; $display("FAIL sp_load_clr_ovf: got %b want 0", SpOverflow); end
  endtask

  task automatic test_sp_underflow();
    logic [15:0] v;
    op(4'b0010, 2'b10, 2'b00, 16'h07F8);
    op(4'b0010, 2'b01, 2'b11, 16'h0000);
    rd(2'd1, v);
    checks++; if (v !== 16'h07F8) begin errors++; $display("FAIL sp_inc8_hold: got %h want %h", v, 16'h07F8); end
    checks++; if (SpUnderflow !== 1'b1) begin errors++; $display("FAIL sp_unf_set8: got %b want 1", SpUnderflow); end
    op(4'b0010, 2'b10, 2'b00, 16'h07FF);
    op(4'b0010, 2'b01, 2'b00, 16'h0000);
    rd(2'd1, v);
    checks++; if (v !== 16'h07FF) begin errors++; $display("FAIL sp_unf_hold: got %h want %h", v, 16'h07FF); end
    checks++; if (SpUnderflow !== 1'b1) begin errors++; $display("FAIL sp_unf_set: got %b want 1", SpUnderflow); end
    op(4'b0010, 2'b00, 2'b00, 16'h0000);
    op(4'b0001, 2'b01, 2'b00, 16'h0000);
    rd(2'd1, v);
    checks++; if (v !== 16'h07FE) begin errors++; $display("FAIL sp_dec_after_unf: got %h want %h", v, 16'h07FE); end
    checks++; if (SpUnderflow !== 1'b1) begin errors++; $display("FAIL sp_unf_sticky: got %b want 1", SpUnderflow); end
    op(4'b0010, 2'b11, 2'b00, 16'h0000);
    rd(2'd1, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL sp_clear: got %h want %h", v, 16'h0000); end
    checks++; if ({SpOverflow, SpUnderflow} !== 2'b01) begin errors++; $display("FAIL sp_clear_flags: got %b want 01", {SpOverflow, SpUnderflow}); end
    op(4'b0010, 2'b00, 2'b00, 16'h0000);
    rd(2'd1, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL sp_dec_from0: got %h want %h", v, 16'h0000); end
    checks++; if ({SpOverflow, SpUnderflow} !== 2'b11) begin errors++; $display("FAIL sp_both_flags: got %b want 11", {SpOverflow, SpUnderflow}); end
    op(4'b0010, 2'b10, 2'b00, 16'h0600);
    checks++; if ({SpOverflow, SpUnderflow} !== 2'b00) begin errors++; $display("FAIL sp_load_clr_both: got %b want 00", {SpOverflow, SpUnderflow}); end
  endtask

  task automatic test_multi();
    logic [15:0] v;
    op(4'b1100, 2'b10, 2'b00, 16'h1234);
    rd(2'd2, v);
    checks++; if (v !== 16'h1234) begin errors++; $display("FAIL multi_r2: got %h want %h", v, 16'h1234); end
    rd(2'd3, v);
    checks++; if (v !== 16'h1234) begin errors++; $display("FAIL multi_r3: got %h want %h", v, 16'h1234); end
    rd(2'd0, v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL multi_r0: got %h want %h", v, 16'h0001); end
    rd(2'd1, v);
    checks++; if (v !== 16'h0600) begin errors++; $display("FAIL multi_r1: got %h want %h", v, 16'h0600); end
    OutCSel = 2'd3; OutDSel = 2'd3; #1;
    checks++; if (OutC !== OutD || OutD !== 16'h1234) begin errors++; $display("FAIL same_index: got C=%h D=%h want %h", OutC, OutD, 16'h1234); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    op(4'b0010, 2'b10, 2'b00, 16'h0400);
    op(4'b0010, 2'b00, 2'b11, 16'h0000);
    checks++; if (SpOverflow !== 1'b1) begin errors++; $display("FAIL mid_pre_flag: got %b want 1", SpOverflow); end
    Reset = 1'b1;
    op(4'b1111, 2'b01, 2'b11, 16'h0000);
    Reset = 1'b0;
    OutCSel = 2'd0; OutDSel = 2'd1; #1;
    checks++; if (OutC !== 16'h0000 || OutD !== 16'h07FF) begin errors++; $display("FAIL mid_reset_regs: got %h/%h want 0000/07ff", OutC, OutD); end
    rd(2'd2, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL mid_reset_r2: got %h want %h", v, 16'h0000); end
    checks++; if ({SpOverflow, SpUnderflow} !== 2'b00) begin errors++; $display("FAIL mid_reset_flags: got %b want 00", {SpOverflow, SpUnderflow}); end
  endtask

  initial begin
    Reset = 1'b0; RegSel = '0; FunSel = '0; Step = '0; I = '0; OutCSel = '0; OutDSel = '0;
    @(negedge Clock);
    test_reset();
    test_pc_inc();
    test_wrap();
    test_sp_overflow();
    test_sp_underflow();
    test_multi();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
